bird_physics_unit: RTL and testbench
====================================

Name:
bird_physics_unit

Overview:
- Parametrised successor to the bird move/draw pair.
- Owns the bird's vertical physics: fixed-point position and velocity, gravity, flap impulse and terminal velocity.
- Adds a game-flow state machine: idle hover, play, hit-fall, respawn with blinking invulnerability, and game over with a lives counter.
- Sits between the keypad/wheel decode and the bird draw block; its position outputs feed drawing and the collision logic.

Parameters:
START_X, 100, fixed bird x position in pixels
START_Y, 200, spawn/hover y position in pixels
FLOOR_Y, 440, y of ground line in pixels
BIRD_H, 32, bird height in pixels
FRAC, 4, fractional bits of position and velocity
GRAVITY, 6, velocity increment per frame, in 2^-FRAC px/frame
FLAP_VEL, 80, upward velocity magnitude set by a flap, in 2^-FRAC px/frame
MAX_VEL, 128, downward terminal velocity, in 2^-FRAC px/frame
LIVES, 3, lives at game start, range 1..7
INVULN_FRAMES, 60, respawn invulnerability length in frames
BLINK_PERIOD, 8, frames per visibility toggle during respawn

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
startOfFrame  in  1  one-clk pulse per video frame; all physics updates occur only on this pulse
flap_key  in  1  flap button, level, already synchronised
start_key  in  1  start button, level, already synchronised
collision  in  1  one-clk pulse from collision logic (bird vs. pipe)
topLeft_x_bird  out  32  always START_X
topLeft_y_bird  out  32  integer part of position, zero-extended
velocity  out  16  signed velocity, 2^-FRAC units; positive is downward
state  out  3  0 IDLE, 1 PLAY, 2 HIT, 3 RESPAWN, 4 OVER
lives  out  3  remaining lives
bird_visible  out  1  gates drawing_bird in the draw block
game_over  out  1  high in OVER

Behaviour:
- Reset (asynchronous, any time):
  - Registered outputs: state=IDLE, y=START_Y<<FRAC, v=0, lives=LIVES, bird_visible=1, game_over=0.
  - All edge and sticky latches are cleared.
  - Reset mid-frame discards any pending flap or collision.
- Input edges:
  - Rising edges of flap_key and start_key are detected every clk.
  - Each edge sets a sticky request held until the next startOfFrame, which consumes it.
  - A collision pulse sets a sticky hit flag, consumed the same way.
  - All state, position, velocity and counter changes happen on the clk edge where startOfFrame=1. Outputs therefore change 1 clk after the tick.
- Physics (PLAY and HIT), per tick:
  - v_next = -FLAP_VEL if a flap is accepted, otherwise min(v+GRAVITY, MAX_VEL).
  - y_next = y + v_next, computed in signed arithmetic wide enough to hold 32+FRAC bits.
  - Ceiling: if y_next < 0, then y=0 and v=0.
  - Floor: if y_next >= (FLOOR_Y-BIRD_H)<<FRAC, then y is clamped to the floor and the floor-hit event fires.
- IDLE:
  - y and v are held and the bird is visible.
  - A flap or start request moves to PLAY. A flap applies the impulse on that same tick; start alone gives v=0 physics on that tick.
- PLAY:
  - Flaps are accepted.
  - A hit flag or floor-hit moves to HIT with lives decremented.
  - If a collision and a flap land on the same tick, the collision wins and the flap is discarded.
- HIT:
  - Flaps are ignored and gravity continues.
  - On floor-hit: lives==0 moves to OVER; otherwise RESPAWN with y=START_Y<<FRAC, v=0.
- RESPAWN:
  - Position is held and collisions are ignored.
  - A frame counter runs from 0 to INVULN_FRAMES-1.
  - bird_visible = bit log2(BLINK_PERIOD) of the counter, inverted, so visibility starts at 1.
  - At count INVULN_FRAMES-1 the block moves to PLAY with bird_visible=1.
  - Requests are consumed and ignored while in RESPAWN.
- OVER:
  - game_over=1; y and v are held.
  - A start request moves to IDLE with lives=LIVES, y=START_Y<<FRAC, v=0.
  - Flap requests are ignored.
- Counter and range rules:
  - lives never underflows, since the lives==0 check precedes the decrement path.
  - velocity is sign-extended or truncated to 16 bits, and |v| never exceeds max(FLAP_VEL, MAX_VEL).

Decomposition:
- Shared package bird_pkg holds the state enum, the FRAC-based fixed-point width constant, and the log2 helper used for BLINK_PERIOD.
- One natural sub-module, bird_edge_latch: rising-edge detection plus a sticky request cleared on startOfFrame. It is instantiated three times (flap, start, collision).
- Physics arithmetic and the FSM stay in the top module.

Test Plan:
- Reset, then start_key edge, then 1 tick: state=PLAY, v=0, y=200. Subsequent ticks: v=6, y_fixed=3206; then v=12, y_fixed=3218. On tick 22 of the fall, v saturates at 128 (it is 126 on tick 21).
- In IDLE, flap edge then tick: state=PLAY, v=-80, topLeft_y_bird=195. Next tick: v=-74, y_fixed=3046 (190 px). Two flap edges between ticks count as one flap.
- In PLAY, collision pulse and flap edge in the same frame, then tick: state=HIT, lives=2, v=prior v+6. The bird falls to y=408, then state=RESPAWN with y=200.
- In RESPAWN, bird_visible toggles every 8 ticks starting at 1, and a collision pulse has no effect. After 60 ticks: state=PLAY, bird_visible=1.
- Lose 3 lives via floor-hits: state=OVER, game_over=1, lives=0, and flap is ignored. A start edge then tick gives state=IDLE, lives=3, y=200.
- Assert reset mid-RESPAWN, between ticks, with a flap pending: outputs return to reset values immediately. After release, the first tick does not apply the stale flap.

Source files
------------

// File: rtl/bird_pkg.sv
// Shared types and constant helpers for the bird physics unit.
package bird_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PLAY    = 3'd1,
        ST_HIT     = 3'd2,
        ST_RESPAWN = 3'd3,
        ST_OVER    = 3'd4
    } bird_state_t;

    localparam int PIX_W = 32;

    // Fixed-point register width: 32 pixel bits, FRAC fraction bits, plus sign and carry headroom.
    function automatic int fix_width(input int frac);
        return PIX_W + frac + 2;
    endfunction

    function automatic int log2_floor(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((value >> i) > 1) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bird_edge_latch.sv
// Rising-edge detector with a sticky request that survives until the next frame tick.
module bird_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic start_of_frame,
    input  logic key,
    output logic req
);

    logic prev_r;
    logic pend_r;
    logic rise_s;

    assign rise_s = key & ~prev_r;
    // An edge arriving on the tick clock itself is still honoured by that tick.
    assign req    = pend_r | rise_s;

    // Edge history and sticky request, consumed by the frame tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_r <= 1'b0;
            pend_r <= 1'b0;
        end else begin
            prev_r <= key;
            if (start_of_frame) begin
                pend_r <= 1'b0;
            end else begin
                pend_r <= pend_r | rise_s;
            end
        end
    end

endmodule

// File: rtl/bird_physics_unit.sv
// Bird vertical physics (fixed-point y/v, gravity, flap, terminal velocity) and game-flow FSM.
module bird_physics_unit
    import bird_pkg::*;
#(
    parameter int START_X       = 100,
    parameter int START_Y       = 200,
    parameter int FLOOR_Y       = 440,
    parameter int BIRD_H        = 32,
    parameter int FRAC          = 4,
    parameter int GRAVITY       = 6,
    parameter int FLAP_VEL      = 80,
    parameter int MAX_VEL       = 128,
    parameter int LIVES         = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_PERIOD  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        flap_key,
    input  logic        start_key,
    input  logic        collision,
    output logic [31:0] topLeft_x_bird,
    output logic [31:0] topLeft_y_bird,
    output logic [15:0] velocity,
    output logic [2:0]  state,
    output logic [2:0]  lives,
    output logic        bird_visible,
    output logic        game_over
);

    localparam int FW        = fix_width(FRAC);
    localparam int BLINK_BIT = log2_floor(BLINK_PERIOD);
    localparam int CNT_A     = $clog2(INVULN_FRAMES) + 1;
    localparam int CNT_W     = (CNT_A > BLINK_BIT + 1) ? CNT_A : BLINK_BIT + 1;

    localparam logic signed [FW-1:0]  START_FIX  = FW'(START_Y) <<< FRAC;
    localparam logic signed [FW-1:0]  FLOOR_FIX  = FW'(FLOOR_Y - BIRD_H) <<< FRAC;
    localparam logic signed [15:0]    GRAV_V     = 16'(GRAVITY);
    localparam logic signed [15:0]    FLAP_V     = 16'(FLAP_VEL);
    localparam logic signed [15:0]    MAX_V      = 16'(MAX_VEL);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(INVULN_FRAMES - 1);
    localparam logic [2:0]            LIVES_INIT = 3'(LIVES);

    bird_state_t              state_r;
    bird_state_t              state_n;
    logic signed [FW-1:0]     y_r;
    logic signed [FW-1:0]     y_n;
    logic signed [FW-1:0]     y_sum_s;
    logic signed [FW-1:0]     y_phys_s;
    logic signed [15:0]       v_r;
    logic signed [15:0]       v_n;
    logic signed [16:0]       v_sum_s;
    logic signed [15:0]       v_grav_s;
    logic signed [15:0]       v_cand_s;
    logic signed [15:0]       v_phys_s;
    logic [2:0]               lives_r;
    logic [2:0]               lives_n;
    logic [CNT_W-1:0]         cnt_r;
    logic [CNT_W-1:0]         cnt_n;
    logic                     vis_r;
    logic                     vis_n;
    logic                     over_r;
    logic                     over_n;
    logic                     flap_req_s;
    logic                     start_req_s;
    logic                     hit_req_s;
    logic                     flap_ok_s;
    logic                     floor_hit_s;

    bird_edge_latch u_flap_latch (
        .clk            (clk),
        .reset          (reset),
        .start_of_frame (startOfFrame),
        .key            (flap_key),
        .req            (flap_req_s)
    );

    bird_edge_latch u_start_latch (
        .clk            (clk),
        .reset          (reset),
        .start_of_frame (startOfFrame),
        .key            (start_key),
        .req            (start_req_s)
    );

    bird_edge_latch u_hit_latch (
        .clk            (clk),
        .reset          (reset),
        .start_of_frame (startOfFrame),
        .key            (collision),
        .req            (hit_req_s)
    );

    // Candidate physics step: velocity update, position integrate, ceiling and floor clamps.
    always_comb begin
        v_sum_s = 17'(v_r) + 17'(GRAV_V);
        if (v_sum_s > 17'(MAX_V)) begin
            v_grav_s = MAX_V;
        end else begin
            v_grav_s = v_sum_s[15:0];
        end

        case (state_r)
            ST_IDLE: flap_ok_s = flap_req_s;
            ST_PLAY: flap_ok_s = flap_req_s & ~hit_req_s;
            default: flap_ok_s = 1'b0;
        endcase

        // Leaving IDLE on start alone integrates with zero velocity.
        if (flap_ok_s) begin
            v_cand_s = -FLAP_V;
        end else if (state_r == ST_IDLE) begin
            v_cand_s = 16'sd0;
        end else begin
            v_cand_s = v_grav_s;
        end

        y_sum_s = y_r + FW'(v_cand_s);
        if (y_sum_s[FW-1]) begin
            y_phys_s    = '0;
            v_phys_s    = 16'sd0;
            floor_hit_s = 1'b0;
        end else if (y_sum_s >= FLOOR_FIX) begin
            y_phys_s    = FLOOR_FIX;
            v_phys_s    = v_cand_s;
            floor_hit_s = 1'b1;
        end else begin
            y_phys_s    = y_sum_s;
            v_phys_s    = v_cand_s;
            floor_hit_s = 1'b0;
        end
    end

    // Next-state logic for the game-flow FSM.
    always_comb begin
        case (state_r)
            ST_IDLE: begin
                if (flap_req_s | start_req_s) begin
                    state_n = ST_PLAY;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (hit_req_s | floor_hit_s) begin
                    state_n = ST_HIT;
                end else begin
                    state_n = ST_PLAY;
                end
            end
            ST_HIT: begin
                if (!floor_hit_s) begin
                    state_n = ST_HIT;
                end else if (lives_r == 3'd0) begin
                    state_n = ST_OVER;
                end else begin
                    state_n = ST_RESPAWN;
                end
            end
            ST_RESPAWN: begin
                if (cnt_r == CNT_LAST) begin
                    state_n = ST_PLAY;
                end else begin
                    state_n = ST_RESPAWN;
                end
            end
            ST_OVER: begin
                if (start_req_s) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_OVER;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Datapath and output next values chosen by the current state.
    always_comb begin
        y_n     = y_r;
        v_n     = v_r;
        lives_n = lives_r;
        cnt_n   = cnt_r;
        vis_n   = 1'b1;
        over_n  = (state_n == ST_OVER);
        case (state_r)
            ST_IDLE: begin
                if (flap_req_s | start_req_s) begin
                    y_n = y_phys_s;
                    v_n = v_phys_s;
                end else begin
                    y_n = y_r;
                end
            end
            ST_PLAY: begin
                y_n = y_phys_s;
                v_n = v_phys_s;
                if ((hit_req_s | floor_hit_s) && (lives_r != 3'd0)) begin
                    lives_n = lives_r - 3'd1;
                end else begin
                    lives_n = lives_r;
                end
            end
            ST_HIT: begin
                if (floor_hit_s && (lives_r != 3'd0)) begin
                    y_n   = START_FIX;
                    v_n   = 16'sd0;
                    cnt_n = '0;
                end else begin
                    y_n = y_phys_s;
                    v_n = v_phys_s;
                end
            end
            ST_RESPAWN: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_n = '0;
                    vis_n = 1'b1;
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                    vis_n = ~cnt_n[BLINK_BIT];
                end
            end
            ST_OVER: begin
                if (start_req_s) begin
                    lives_n = LIVES_INIT;
                    y_n     = START_FIX;
                    v_n     = 16'sd0;
                end else begin
                    lives_n = lives_r;
                end
            end
            default: begin
                y_n = y_r;
            end
        endcase
    end

    // State and datapath registers; everything advances only on the frame tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            y_r     <= START_FIX;
            v_r     <= 16'sd0;
            lives_r <= LIVES_INIT;
            cnt_r   <= '0;
            vis_r   <= 1'b1;
            over_r  <= 1'b0;
        end else if (startOfFrame) begin
            state_r <= state_n;
            y_r     <= y_n;
            v_r     <= v_n;
            lives_r <= lives_n;
            cnt_r   <= cnt_n;
            vis_r   <= vis_n;
            over_r  <= over_n;
        end
    end

    assign topLeft_x_bird = 32'(START_X);
    assign topLeft_y_bird = y_r[FRAC+31:FRAC];
    assign velocity       = v_r;
    assign state          = state_r;
    assign lives          = lives_r;
    assign bird_visible   = vis_r;
    assign game_over      = over_r;

endmodule

// File: tb/tb_bird_physics_unit.sv
// Self-checking bench for bird_physics_unit: directed game scenarios then randomized frames vs. a behavioural model.
module tb_bird_physics_unit;

    localparam int FLOOR_FIX = (440 - 32) * 16;
    localparam int START_FIX = 200 * 16;

    logic        clk;
    logic        reset;
    logic        startOfFrame;
    logic        flap_key;
    logic        start_key;
    logic        collision;
    logic [31:0] topLeft_x_bird;
    logic [31:0] topLeft_y_bird;
    logic [15:0] velocity;
    logic [2:0]  state;
    logic [2:0]  lives;
    logic        bird_visible;
    logic        game_over;

    int vectors;
    int miscompares;

    // Behavioural model of the game: state 0..4, fixed-point y, signed v.
    int m_state, m_y, m_v, m_lives, m_frames;
    bit m_vis, m_flap, m_start, m_hit;

    bird_physics_unit dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .flap_key       (flap_key),
        .start_key      (start_key),
        .collision      (collision),
        .topLeft_x_bird (topLeft_x_bird),
        .topLeft_y_bird (topLeft_y_bird),
        .velocity       (velocity),
        .state          (state),
        .lives          (lives),
        .bird_visible   (bird_visible),
        .game_over      (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_y = START_FIX; m_v = 0; m_lives = 3; m_frames = 0;
        m_vis = 1'b1; m_flap = 1'b0; m_start = 1'b0; m_hit = 1'b0;
    endtask

    // One physics step; flap_ok selects the impulse, still selects zero velocity.
    task automatic model_phys(input bit flap_ok, input bit still, output bit floor_hit);
        int nv, ny;
        if (flap_ok)    nv = -80;
        else if (still) nv = 0;
        else            nv = (m_v + 6 > 128) ? 128 : m_v + 6;
        ny = m_y + nv;
        floor_hit = 1'b0;
        if (ny < 0) begin
            m_y = 0; m_v = 0;
        end else if (ny >= FLOOR_FIX) begin
            m_y = FLOOR_FIX; m_v = nv; floor_hit = 1'b1;
        end else begin
            m_y = ny; m_v = nv;
        end
    endtask

    task automatic model_tick();
        bit f, s, h, fh;
        f = m_flap; s = m_start; h = m_hit;
        m_flap = 1'b0; m_start = 1'b0; m_hit = 1'b0;
        m_vis = 1'b1;
        if (m_state == 0) begin
            if (f || s) begin
                model_phys(f, !f, fh);
                m_state = 1;
            end
        end else if (m_state == 1) begin
            model_phys(f && !h, 1'b0, fh);
            if (h || fh) begin
                m_state = 2;
                m_lives = m_lives - 1;
            end
        end else if (m_state == 2) begin
            model_phys(1'b0, 1'b0, fh);
            if (fh) begin
                if (m_lives == 0) begin
                    m_state = 4;
                end else begin
                    m_state = 3; m_y = START_FIX; m_v = 0; m_frames = 0;
                end
            end
        end else if (m_state == 3) begin
            if (m_frames == 59) begin
                m_state = 1; m_frames = 0;
            end else begin
                m_frames = m_frames + 1;
                m_vis = ((m_frames / 8) % 2) == 0;
            end
        end else begin
            if (s) begin
                m_state = 0; m_lives = 3; m_y = START_FIX; m_v = 0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_value({tag, ".state"}, int'(state), m_state);
        check_value({tag, ".y"}, int'(topLeft_y_bird), m_y / 16);
        check_value({tag, ".v"}, int'($signed(velocity)), m_v);
        check_value({tag, ".lives"}, int'(lives), m_lives);
        check_value({tag, ".visible"}, int'(bird_visible), int'(m_vis));
        check_value({tag, ".game_over"}, int'(game_over), (m_state == 4) ? 1 : 0);
    endtask

    task automatic tick();
        startOfFrame = 1'b1;
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        model_tick();
        compare_all("tick");
    endtask

    task automatic press_flap();
        flap_key = 1'b1; @(posedge clk); #1;
        flap_key = 1'b0; @(posedge clk); #1;
        m_flap = 1'b1;
    endtask

    task automatic press_start();
        start_key = 1'b1; @(posedge clk); #1;
        start_key = 1'b0; @(posedge clk); #1;
        m_start = 1'b1;
    endtask

    task automatic pulse_collision();
        collision = 1'b1; @(posedge clk); #1;
        collision = 1'b0; @(posedge clk); #1;
        m_hit = 1'b1;
    endtask

    task automatic frame(input bit do_flap, input bit do_start, input bit do_coll);
        if (do_coll)  pulse_collision();
        if (do_flap)  press_flap();
        if (do_start) press_start();
        @(posedge clk); #1;
        tick();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        flap_key = 1'b0; start_key = 1'b0; collision = 1'b0; startOfFrame = 1'b0;
        model_reset();
        #2;
        compare_all("async_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_until(input int target, input int budget);
        int n;
        n = 0;
        while (m_state != target && n < budget) begin
            tick();
            n++;
        end
        if (m_state != target) begin
            check_value("run_until_timeout", m_state, target);
        end
    endtask

    // Walk through the invulnerability window, checking the blink pattern and collision immunity.
    task automatic respawn_walk(input int coll_at);
        for (int k = 1; k <= 60; k++) begin
            if (k == coll_at) pulse_collision();
            tick();
            if (k < 60) begin
                check_value("respawn.state", int'(state), 3);
                check_value("respawn.blink", int'(bird_visible), ((k >> 3) & 1) == 0 ? 1 : 0);
            end else begin
                check_value("respawn.exit_state", int'(state), 1);
                check_value("respawn.exit_visible", int'(bird_visible), 1);
            end
        end
    endtask

    initial begin
        int pv;
        vectors = 0; miscompares = 0;
        reset = 1'b1; startOfFrame = 1'b0;
        flap_key = 1'b0; start_key = 1'b0; collision = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_value("reset.state", int'(state), 0);
        check_value("reset.y", int'(topLeft_y_bird), 200);
        check_value("reset.v", int'($signed(velocity)), 0);
        check_value("reset.lives", int'(lives), 3);
        check_value("reset.visible", int'(bird_visible), 1);
        check_value("reset.game_over", int'(game_over), 0);
        check_value("x_pos", int'(topLeft_x_bird), 100);
        reset = 1'b0;
        @(posedge clk); #1;

        // Flap out of IDLE, then double flap inside one frame.
        frame(1'b1, 1'b0, 1'b0);
        check_value("idle_flap.state", int'(state), 1);
        check_value("idle_flap.v", int'($signed(velocity)), -80);
        check_value("idle_flap.y", int'(topLeft_y_bird), 195);
        tick();
        check_value("idle_flap2.v", int'($signed(velocity)), -74);
        check_value("idle_flap2.y", int'(topLeft_y_bird), 190);
        press_flap();
        frame(1'b1, 1'b0, 1'b0);
        check_value("double_flap.v", int'($signed(velocity)), -80);

        // Start alone, free fall to terminal velocity, floor hit and respawn.
        apply_reset();
        frame(1'b0, 1'b1, 1'b0);
        check_value("start.state", int'(state), 1);
        check_value("start.v", int'($signed(velocity)), 0);
        check_value("start.y", int'(topLeft_y_bird), 200);
        tick();
        check_value("fall1.v", int'($signed(velocity)), 6);
        tick();
        check_value("fall2.v", int'($signed(velocity)), 12);
        for (int t = 3; t <= 21; t++) tick();
        check_value("fall21.v", int'($signed(velocity)), 126);
        tick();
        check_value("fall22.v", int'($signed(velocity)), 128);
        run_until(2, 200);
        check_value("floor.lives", int'(lives), 2);
        check_value("floor.y", int'(topLeft_y_bird), 408);
        tick();
        check_value("respawn_entry.state", int'(state), 3);
        check_value("respawn_entry.y", int'(topLeft_y_bird), 200);
        respawn_walk(5);

        // Collision and flap in the same frame: collision wins.
        repeat (3) tick();
        pv = m_v;
        frame(1'b1, 1'b0, 1'b1);
        check_value("coll_flap.state", int'(state), 2);
        check_value("coll_flap.lives", int'(lives), 1);
        check_value("coll_flap.v", int'($signed(velocity)), pv + 6);
        run_until(3, 200);
        check_value("coll_respawn.y", int'(topLeft_y_bird), 200);
        respawn_walk(20);

        // Last life lost on the floor, OVER ignores flap, start returns to IDLE.
        run_until(2, 200);
        check_value("last_hit.lives", int'(lives), 0);
        run_until(4, 10);
        check_value("over.game_over", int'(game_over), 1);
        check_value("over.lives", int'(lives), 0);
        frame(1'b1, 1'b0, 1'b0);
        check_value("over_flap.state", int'(state), 4);
        frame(1'b0, 1'b1, 1'b0);
        check_value("restart.state", int'(state), 0);
        check_value("restart.lives", int'(lives), 3);
        check_value("restart.y", int'(topLeft_y_bird), 200);

        // Reset mid-RESPAWN with a flap pending; the stale flap must not leave IDLE.
        frame(1'b0, 1'b1, 1'b0);
        run_until(3, 300);
        repeat (4) tick();
        press_flap();
        apply_reset();
        tick();
        check_value("stale_flap.state", int'(state), 0);
        check_value("stale_flap.v", int'($signed(velocity)), 0);

        // Randomized frames.
        for (int i = 0; i < 600; i++) begin
            int r;
            if ($urandom_range(0, 199) == 0) apply_reset();
            r = int'($urandom_range(0, 3));
            repeat (r) @(posedge clk);
            #1;
            frame($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
